// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// FSM state encoding, opcode field values and the invert-bit position.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUM = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  localparam int F_INV = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers the last accepted requester
// and only moves on an accept. Reset leaves last = 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last;

  always_comb begin
    gnt_id = (req == 2'b11) ? ~last : req[1];
    gnt[0] = (|req) & ~gnt_id;
    gnt[1] = (|req) &  gnt_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= 1'b1;
    else if (accept) last <= gnt_id;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU: IDLE accepts one op, EXEC computes, RESP holds
// the result until handshake. Define ALU_ARB_STATS_EN to add saturating op/overflow counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         Req0Valid,
  input  logic         Req1Valid,
  output logic         Req0Ready,
  output logic         Req1Ready,
  input  logic [N-1:0] Req0A,
  input  logic [N-1:0] Req0B,
  input  logic [N-1:0] Req1A,
  input  logic [N-1:0] Req1B,
  input  logic [2:0]   Req0F,
  input  logic [2:0]   Req1F,
  output logic         RespValid,
  input  logic         RespReady,
  output logic         RespId,
  output logic [N-1:0] RespY,
  output logic         RespOverflow,
  output logic         RespZero,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]  OpCount0,
  output logic [15:0]  OpCount1,
  output logic [15:0]  OvfCount,
`endif
  output logic         Busy
);

  state_t       state;
  logic [N-1:0] a_q, b_q;
  logic [2:0]   f_q;
  logic         id_q;
  logic [1:0]   gnt;
  logic         gnt_id;
  logic         idle, accept;

  assign idle   = (state == IDLE);
  assign accept = idle & (Req0Valid | Req1Valid);

  rr_arbiter2 u_rr (
    .clk    (Clk),
    .rst_n  (nReset),
    .req    ({Req1Valid, Req0Valid}),
    .accept (accept),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign Req0Ready = idle & gnt[0];
  assign Req1Ready = idle & gnt[1];

  // Datapath works only on latched operands, so requester inputs may change freely after accept
  logic         inv;
  logic [N-1:0] bx, sum, y_c;
  logic         ovf_c, zero_c;

  always_comb begin
    inv    = f_q[F_INV];
    bx     = inv ? ~b_q : b_q;
    sum    = a_q + bx + {{(N-1){1'b0}}, inv};
    ovf_c  = (a_q[N-1] == bx[N-1]) && (sum[N-1] != a_q[N-1]);
    zero_c = (sum == '0);
    y_c    = '0;
    case (f_q[1:0])
      OP_AND:  y_c = a_q & bx;
      OP_OR:   y_c = a_q | bx;
      OP_SUM:  y_c = sum;
      OP_SLT:  y_c = {{(N-1){1'b0}}, sum[N-1]};
      default: y_c = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      Busy         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      f_q          <= '0;
      id_q         <= 1'b0;
      RespValid    <= 1'b0;
      RespY        <= '0;
      RespId       <= 1'b0;
      RespOverflow <= 1'b0;
      RespZero     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q   <= gnt_id ? Req1A : Req0A;
          b_q   <= gnt_id ? Req1B : Req0B;
          f_q   <= gnt_id ? Req1F : Req0F;
          id_q  <= gnt_id;
          state <= EXEC;
          Busy  <= 1'b1;
        end
        EXEC: begin
          RespY        <= y_c;
          RespOverflow <= ovf_c;
          RespZero     <= zero_c;
          RespId       <= id_q;
          RespValid    <= 1'b1;
          state        <= RESP;
        end
        RESP: if (RespReady) begin
          RespValid <= 1'b0;
          state     <= IDLE;
          Busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          RespValid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      OpCount0 <= '0;
      OpCount1 <= '0;
      OvfCount <= '0;
    end else begin
      if (Req0Ready && Req0Valid && OpCount0 != 16'hFFFF) OpCount0 <= OpCount0 + 16'd1;
      if (Req1Ready && Req1Valid && OpCount1 != 16'hFFFF) OpCount1 <= OpCount1 + 16'd1;
      if (RespValid && RespReady && RespOverflow && OvfCount != 16'hFFFF)
        OvfCount <= OvfCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table-driven ops through a response scoreboard,
// plus round-robin, backpressure and mid-op reset sequences.
module tb_alu_arbiter;
  localparam int N = 32;

  logic         Clk = 1'b0;
  logic         nReset;
  logic         Req0Valid, Req1Valid, Req0Ready, Req1Ready;
  logic [N-1:0] Req0A, Req0B, Req1A, Req1B;
  logic [2:0]   Req0F, Req1F;
  logic         RespValid, RespReady, RespId, RespOverflow, RespZero, Busy;
  logic [N-1:0] RespY;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]  OpCount0, OpCount1, OvfCount;
`endif

  alu_arbiter #(.N(N)) dut (
    .Clk(Clk), .nReset(nReset),
    .Req0Valid(Req0Valid), .Req1Valid(Req1Valid),
    .Req0Ready(Req0Ready), .Req1Ready(Req1Ready),
    .Req0A(Req0A), .Req0B(Req0B), .Req1A(Req1A), .Req1B(Req1B),
    .Req0F(Req0F), .Req1F(Req1F),
    .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId),
    .RespY(RespY), .RespOverflow(RespOverflow), .RespZero(RespZero),
`ifdef ALU_ARB_STATS_EN
    .OpCount0(OpCount0), .OpCount1(OpCount1), .OvfCount(OvfCount),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic         id;
    logic [N-1:0] a, b;
    logic [2:0]   f;
    logic [N-1:0] y;
    logic         ovf, zero;
  } vec_t;

  typedef struct {
    logic         id;
    logic [N-1:0] y;
    logic         ovf, zero;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t tbl[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic drive(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] f, input logic v);
    if (id) begin Req1A = a; Req1B = b; Req1F = f; Req1Valid = v; end
    else    begin Req0A = a; Req0B = b; Req0F = f; Req0Valid = v; end
  endtask

  // Called at a falling edge; returns at falling edge + 1 of the cycle RespValid is due
  task automatic run_op(input vec_t v);
    bit got = 0;
    drive(v.id, v.a, v.b, v.f, 1'b1);
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (v.id ? Req1Ready : Req0Ready) begin
        got = 1;
        sbq.push_back('{v.id, v.y, v.ovf, v.zero});
      end
      @(negedge Clk);
    end
    drive(v.id, ~v.a, ~v.b, ~v.f, 1'b0);
    if (!got) fail_now("accept");
    else begin
      #1;
      chk("lat_exec_valid", RespValid, 0);
      chk("lat_exec_busy", Busy, 1);
      @(negedge Clk);
      #1;
      chk("lat_t2_valid", RespValid, 1);
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 20 && sbq.size() != 0; c++) @(negedge Clk);
    if (sbq.size() != 0) begin
      fail_now("drain");
      sbq.delete();
    end
    @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    nReset = 1'b0;
    Req0Valid = 0; Req1Valid = 0;
    sbq.delete();
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
  endtask

  // Response scoreboard and ready-exclusivity monitor, sampled mid-low-phase
  always @(negedge Clk) begin
    #2;
    if (nReset) begin
      checks++;
      if ((Req0Ready && Req1Ready) || (Busy && (Req0Ready || Req1Ready))) begin
        errors++;
        $display("FAIL ready_excl: got r0=%b r1=%b busy=%b expected exclusive and idle-only",
                 Req0Ready, Req1Ready, Busy);
      end
      if (RespValid && RespReady) begin
        if (sbq.size() == 0) fail_now("unexpected_resp");
        else begin
          mon_e = sbq.pop_front();
          chk("resp_id", RespId, mon_e.id);
          chk("resp_y", RespY, mon_e.y);
          chk("resp_ovf", RespOverflow, mon_e.ovf);
          chk("resp_zero", RespZero, mon_e.zero);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   ng;
    logic g;

    tbl[0]  = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 32'h00000003, 32'h00000005, 3'b111, 32'h00000001, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'h00000000, 32'h00000000, 3'b100, 32'h00000000, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 32'h80000000, 32'h80000000, 3'b010, 32'h00000000, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 32'h00000005, 32'h00000003, 3'b111, 32'h00000000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b111, 32'h00000001, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 32'h12345678, 32'h12345678, 3'b101, 32'hFFFFFFFF, 1'b0, 1'b1};

    nReset = 1'b0; RespReady = 1'b1;
    Req0Valid = 0; Req1Valid = 0;
    drive(1'b0, '0, '0, 3'b0, 1'b0);
    drive(1'b1, '0, '0, 3'b0, 1'b0);
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_valid", RespValid, 0);
    chk("rst_y", RespY, 0);
    chk("rst_id", RespId, 0);
    chk("rst_ovf", RespOverflow, 0);
    chk("rst_zero", RespZero, 0);
    chk("rst_busy", Busy, 0);
    @(negedge Clk);
    nReset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i]);
      wait_drain();
    end

    // Both requesters held valid from the first cycle out of reset
    @(negedge Clk);
    nReset = 1'b0;
    sbq.delete();
    drive(1'b0, 32'd1, 32'd2, 3'b010, 1'b1);
    drive(1'b1, 32'd10, 32'd20, 3'b010, 1'b1);
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (Req0Ready || Req1Ready) begin
        g = Req1Ready;
        if (ng == 0) chk("rr_first_cycle", c, 0);
        chk("rr_grant_order", g, ng % 2);
        if (g) sbq.push_back('{1'b1, 32'd30, 1'b0, 1'b0});
        else   sbq.push_back('{1'b0, 32'd3, 1'b0, 1'b0});
        ng++;
      end
      @(negedge Clk);
    end
    Req0Valid = 0; Req1Valid = 0;
    if (ng != 4) fail_now("rr_grants");
    wait_drain();

    // Consumer stalls; result holds and a pending request is not accepted
    RespReady = 1'b0;
    run_op(tbl[0]);
    drive(1'b1, 32'd7, 32'd1, 3'b010, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      #1;
      chk("stall_valid", RespValid, 1);
      chk("stall_y", RespY, 32'h80000000);
      chk("stall_no_ready", Req1Ready | Req0Ready, 0);
    end
    @(negedge Clk);
    Req1Valid = 1'b0;
    RespReady = 1'b1;
    wait_drain();

    // Reset lands in the EXEC cycle; the op must vanish
    drive(1'b0, 32'h7FFFFFFF, 32'h1, 3'b010, 1'b1);
    #1;
    chk("rstx_accept", Req0Ready, 1);
    @(negedge Clk);
    Req0Valid = 1'b0;
    #3;
    nReset = 1'b0;
    #1;
    chk("rstx_valid", RespValid, 0);
    chk("rstx_y", RespY, 0);
    chk("rstx_ovf", RespOverflow, 0);
    chk("rstx_busy", Busy, 0);
    sbq.delete();
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      #1;
      chk("rstx_no_resp", RespValid, 0);
    end
    @(negedge Clk);
    run_op(tbl[5]);
    wait_drain();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    #1;
    chk("stat_rst0", OpCount0, 0);
    chk("stat_rst_ovf", OvfCount, 0);
    @(negedge Clk);
    run_op(tbl[0]); wait_drain();
    run_op(tbl[3]); wait_drain();
    run_op(tbl[4]); wait_drain();
    run_op(tbl[1]); wait_drain();
    chk("stat_op0", OpCount0, 3);
    chk("stat_op1", OpCount1, 1);
    chk("stat_ovf", OvfCount, 1);
`else
    do_reset();
    @(negedge Clk);
    v = tbl[2];
    run_op(v);
    wait_drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
